// File: rtl/operand_mux_pkg.sv
// operand_mux_pkg: shared widths and select-code constants for the operand selector
package operand_mux_pkg;
  localparam int DATA_W = 16;
  localparam int N_IN = 8;
  localparam int SEL_W = $clog2(N_IN);
  localparam logic [SEL_W-1:0] SEL_IN0 = 3'd0;
  localparam logic [SEL_W-1:0] SEL_IN1 = 3'd1;
  localparam logic [SEL_W-1:0] SEL_IN2 = 3'd2;
  localparam logic [SEL_W-1:0] SEL_IN3 = 3'd3;
  localparam logic [SEL_W-1:0] SEL_IN4 = 3'd4;
  localparam logic [SEL_W-1:0] SEL_IN5 = 3'd5;
  localparam logic [SEL_W-1:0] SEL_IN6 = 3'd6;
  localparam logic [SEL_W-1:0] SEL_IN7 = 3'd7;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/operand_mux_sel.sv
// operand_mux_sel: combinational 8:1 operand multiplexer
module operand_mux_sel
  import operand_mux_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic [DATA_W-1:0] data
);
  always_comb begin
    data = in0;
    case (sel)
      SEL_IN0: data = in0;
      SEL_IN1: data = in1;
      SEL_IN2: data = in2;
      SEL_IN3: data = in3;
      SEL_IN4: data = in4;
      SEL_IN5: data = in5;
      SEL_IN6: data = in6;
      SEL_IN7: data = in7;
      default: data = in0;
    endcase
  end
endmodule

// File: rtl/operand_mux.sv
// operand_mux: registered 8:1 operand selector with valid flag, one-cycle latency
module operand_mux
  import operand_mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_valid,
  output logic [DATA_W-1:0] out,
  output logic              out_valid
);
  data_t mux_data;
  operand_mux_sel u_sel (
    .sel(sel), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .in4(in4), .in5(in5), .in6(in6), .in7(in7), .data(mux_data)
  );
  // out holds its last capture while idle; only valid drops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      out <= sel_valid ? mux_data : out;
      out_valid <= sel_valid;
    end
  end
endmodule

// File: tb/tb_operand_mux.sv
// tb_operand_mux: table-driven check of the registered operand selector
module tb_operand_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0][15:0] ins;
  logic [2:0] sel = '0;
  logic sel_valid = 1'b0;
  logic [15:0] out;
  logic out_valid;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    logic rst_n;
    logic sv;
    logic [2:0] sel;
    logic [7:0][15:0] ins;
    logic [15:0] eo;
    logic eov;
  } vec_t;

  always #5 clk = ~clk;

  operand_mux dut (
    .clk(clk), .rst_n(rst_n),
    .in0(ins[0]), .in1(ins[1]), .in2(ins[2]), .in3(ins[3]),
    .in4(ins[4]), .in5(ins[5]), .in6(ins[6]), .in7(ins[7]),
    .sel(sel), .sel_valid(sel_valid), .out(out), .out_valid(out_valid)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic sv, input logic [2:0] s,
                              input logic [7:0][15:0] i, input logic [15:0] eo, input logic eov);
    mk = '{rst_n: r, sv: sv, sel: s, ins: i, eo: eo, eov: eov};
  endfunction

  initial begin
    vec_t vt[$];
    logic [7:0][15:0] base, hold_ins, ext;
    logic [15:0] sweep_exp [8];
    sweep_exp = '{16'd15, 16'd32, 16'd86, 16'd43, 16'd14, 16'd93, 16'd11, 16'd98};
    for (int k = 0; k < 8; k++) base[k] = sweep_exp[k];
    hold_ins = base;
    hold_ins[5] = 16'd500;
    ext = base;
    ext[7] = 16'hFFFF;
    ext[0] = 16'h0000;
    vt.push_back(mk(1'b0, 1'b1, 3'b011, base, 16'd0, 1'b0));
    vt.push_back(mk(1'b0, 1'b1, 3'b011, base, 16'd0, 1'b0));
    for (int k = 0; k < 8; k++) vt.push_back(mk(1'b1, 1'b1, 3'(k), base, sweep_exp[k], 1'b1));
    vt.push_back(mk(1'b1, 1'b1, 3'b101, base, 16'd93, 1'b1));
    vt.push_back(mk(1'b1, 1'b0, 3'b010, hold_ins, 16'd93, 1'b0));
    vt.push_back(mk(1'b1, 1'b0, 3'b101, hold_ins, 16'd93, 1'b0));
    vt.push_back(mk(1'b1, 1'b1, 3'b111, ext, 16'hFFFF, 1'b1));
    vt.push_back(mk(1'b1, 1'b1, 3'b000, ext, 16'h0000, 1'b1));
    vt.push_back(mk(1'b1, 1'b1, 3'b111, ext, 16'hFFFF, 1'b1));
    vt.push_back(mk(1'b1, 1'b1, 3'b000, ext, 16'h0000, 1'b1));
    vt.push_back(mk(1'b1, 1'b1, 3'b111, base, 16'd98, 1'b1));
    vt.push_back(mk(1'b0, 1'b1, 3'b111, base, 16'd0, 1'b0));
    vt.push_back(mk(1'b1, 1'b1, 3'b001, base, 16'd32, 1'b1));
    ins = base;
    foreach (vt[i]) begin
      @(negedge clk);
      rst_n = vt[i].rst_n;
      sel_valid = vt[i].sv;
      sel = vt[i].sel;
      ins = vt[i].ins;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out", i), out, vt[i].eo);
      check($sformatf("vec%0d_valid", i), {15'd0, out_valid}, {15'd0, vt[i].eov});
    end
    // data changing between edges: only the value present at the capturing edge counts
    @(negedge clk);
    ins = base;
    sel = 3'b010;
    sel_valid = 1'b1;
    #2 ins[2] = 16'd200;
    check("no_comb_path", out, 16'd32);
    @(posedge clk);
    #1;
    check("late_change_out", out, 16'd200);
    check("late_change_valid", {15'd0, out_valid}, 16'd1);
    @(negedge clk);
    sel_valid = 1'b0;
    ins[2] = 16'd7;
    @(posedge clk);
    #1;
    ins[2] = 16'd9;
    #2;
    check("idle_change_out", out, 16'd200);
    check("idle_change_valid", {15'd0, out_valid}, 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
